idct_mac_accumulator: RTL and testbench

- Downstream stage of the IDCT multiplier wrapper.
- Consumes the wrapper's 32-bit registered product stream P, one product per handshake, and sums TERMS consecutive products into one dot-product.
- Rounds the sum and right-shifts it, then narrows it to an OUT_W coefficient.
- Holds the result in a one-entry output register with valid/ready handshake toward the transpose/row buffer.

---
 rtl/idct_mac_accumulator.sv | 188 ++++++++++++++++++
 tb/tb_idct_mac_accumulator.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : idct_mac_accumulator
// Description : Dot-product accumulator placed after the IDCT multiplier
//               wrapper. Sums TERMS consecutive signed products, rounds
//               (half-up), arithmetic-shifts right by SHIFT and narrows the
//               result to OUT_W bits. The result sits in a one-entry output
//               register with a valid/ready handshake.
// Ports       : clk        - clock, rising edge
//               rstP       - asynchronous active-high reset
//               clr        - synchronous flush of partial sum and output reg
//               p_in       - signed product, P_W bits
//               p_valid    - p_in valid
//               p_ready    - product can be accepted this cycle
//               sum_out    - signed rounded dot-product, OUT_W bits
//               sum_valid  - sum_out valid
//               sum_ready  - consumer accepts sum_out
//               term_cnt   - products accepted into the current sum
//               busy       - partial sum in flight or result pending
//               sat_flag   - result was clamped (IDCT_ACC_SAT_EN only)
// Options     : define IDCT_ACC_SAT_EN to clamp instead of wrap on narrowing.
// Revision    : 1.0 - initial release
// ============================================================================
module idct_mac_accumulator #(
    parameter int P_W   = 32,
    parameter int ACC_W = 40,
    parameter int TERMS = 8,
    parameter int SHIFT = 8,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rstP,
    input  logic                    clr,
    input  logic signed [P_W-1:0]   p_in,
    input  logic                    p_valid,
    output logic                    p_ready,
    output logic signed [OUT_W-1:0] sum_out,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic [$clog2(TERMS):0]  term_cnt,
    output logic                    busy
`ifdef IDCT_ACC_SAT_EN
    ,
    output logic                    sat_flag
`endif
);

    localparam int                      c_cnt_w    = $clog2(TERMS) + 1;
    localparam logic [c_cnt_w-1:0]      c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0]      c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]      c_cnt_last = c_cnt_w'(TERMS - 1);
    localparam logic signed [ACC_W-1:0] c_round    = ACC_W'(1) << (SHIFT - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_stall = 2'd2;

    logic signed [ACC_W-1:0] r_acc;
    logic [c_cnt_w-1:0]      r_term_cnt;
    logic signed [OUT_W-1:0] r_sum_out;
    logic                    r_sum_valid;
    logic [1:0]              r_state;

    logic signed [ACC_W-1:0] w_p_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_rounded;
    logic signed [ACC_W-1:0] w_r;
    logic [OUT_W-1:0]        w_narrow;
    logic                    w_at_last;
    logic                    w_accept;
    logic                    w_final;
    logic                    w_pop;

    assign w_at_last = (r_term_cnt == c_cnt_last);
    assign w_accept  = p_valid && p_ready;
    assign w_final   = w_accept && w_at_last;
    assign w_pop     = r_sum_valid && sum_ready;

    // Only the last term of a sum has to wait for room in the output register.
    assign p_ready   = !(w_at_last && r_sum_valid && !sum_ready);
    assign busy      = (r_term_cnt != c_cnt_zero) || r_sum_valid;
    assign term_cnt  = r_term_cnt;
    assign sum_out   = r_sum_out;
    assign sum_valid = r_sum_valid;

    // The first term loads rather than adds, so no explicit clear is needed
    // between consecutive dot-products.
    assign w_p_ext   = {{(ACC_W - P_W){p_in[P_W-1]}}, p_in};
    assign w_sum     = (r_term_cnt == c_cnt_zero) ? w_p_ext : (r_acc + w_p_ext);
    assign w_rounded = w_sum + c_round;
    assign w_r       = w_rounded >>> SHIFT;

`ifdef IDCT_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic w_sat;
    logic r_sat_flag;

    always_comb begin
        w_sat    = 1'b0;
        w_narrow = w_r[OUT_W-1:0];
        if (w_r > c_sat_max) begin
            w_sat    = 1'b1;
            w_narrow = c_sat_max[OUT_W-1:0];
        end else if (w_r < c_sat_min) begin
            w_sat    = 1'b1;
            w_narrow = c_sat_min[OUT_W-1:0];
        end
    end

    assign sat_flag = r_sat_flag;
`else
    // Plain two's-complement wrap: the upper bits are simply dropped.
    logic w_unused_hi;
    assign w_narrow    = w_r[OUT_W-1:0];
    assign w_unused_hi = ^w_r[ACC_W-1:OUT_W];
`endif

    always_ff @(posedge clk or posedge rstP) begin
        if (rstP) begin
            r_acc       <= '0;
            r_term_cnt  <= '0;
            r_sum_out   <= '0;
            r_sum_valid <= 1'b0;
            r_state     <= c_st_idle;
`ifdef IDCT_ACC_SAT_EN
            r_sat_flag  <= 1'b0;
`endif
        end else if (clr) begin
            // A product offered alongside clr is consumed and dropped; sum_out
            // keeps its last value.
            r_acc       <= '0;
            r_term_cnt  <= '0;
            r_sum_valid <= 1'b0;
            r_state     <= c_st_idle;
`ifdef IDCT_ACC_SAT_EN
            r_sat_flag  <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_acc <= w_sum;
                if (w_final) begin
                    r_term_cnt <= '0;
                    r_sum_out  <= w_narrow;
`ifdef IDCT_ACC_SAT_EN
                    r_sat_flag <= w_sat;
`endif
                end else begin
                    r_term_cnt <= r_term_cnt + c_cnt_one;
                end
            end

            // A completion in the same cycle as a pop refills the register
            // with no bubble.
            if (w_final) begin
                r_sum_valid <= 1'b1;
            end else if (w_pop) begin
                r_sum_valid <= 1'b0;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_state <= w_final ? c_st_idle : c_st_accum;
                    end
                end
                c_st_accum: begin
                    if (w_final) begin
                        r_state <= c_st_idle;
                    end else if (w_at_last && !p_ready) begin
                        r_state <= c_st_stall;
                    end
                end
                c_st_stall: begin
                    if (w_final) begin
                        r_state <= c_st_idle;
                    end else if (w_pop) begin
                        r_state <= c_st_accum;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_idct_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_idct_mac_accumulator
// Description : Self-checking bench for idct_mac_accumulator. A driver issues
//               directed and random stimulus and pushes expected results into
//               a scoreboard queue; a negedge monitor compares every handshake
//               and the per-cycle status outputs against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idct_mac_accumulator;

    localparam int TERMS = 8;

    logic               clk       = 1'b0;
    logic               rstP      = 1'b1;
    logic               clr       = 1'b0;
    logic signed [31:0] p_in      = '0;
    logic               p_valid   = 1'b0;
    logic               sum_ready = 1'b0;
    logic               p_ready;
    logic [15:0]        sum_out;
    logic               sum_valid;
    logic [3:0]         term_cnt;
    logic               busy;
`ifdef IDCT_ACC_SAT_EN
    logic               sat_flag;
`endif

    idct_mac_accumulator dut (
        .clk       (clk),
        .rstP      (rstP),
        .clr       (clr),
        .p_in      (p_in),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .term_cnt  (term_cnt),
        .busy      (busy)
`ifdef IDCT_ACC_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        bit          sat;
    } exp_t;

    int          total = 0;
    int          bad   = 0;

    // Reference model state: products gathered so far, output register
    // occupancy and the last produced result.
    int          m_cnt      = 0;
    longint      m_sum      = 0;
    bit          m_full     = 1'b0;
    logic [15:0] m_last     = '0;
    bit          m_last_sat = 1'b0;
    bit          m_acc      = 1'b0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Round half up, floor-divide by 2^8, then wrap or clamp to 16 bits.
    function automatic exp_t ref_result(input longint s);
        exp_t   e;
        longint t;
        longint q;
        t = s + 128;
        q = t / 256;
        if ((t % 256) != 0 && t < 0) q = q - 1;
        e.sat = 1'b0;
`ifdef IDCT_ACC_SAT_EN
        if (q > 32767) begin
            q = 32767;
            e.sat = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            e.sat = 1'b1;
        end
`endif
        e.val = q[15:0];
        return e;
    endfunction

    function automatic bit exp_ready();
        return !(m_cnt == TERMS - 1 && m_full && !sum_ready);
    endfunction

    task automatic model_reset();
        m_cnt      = 0;
        m_sum      = 0;
        m_full     = 1'b0;
        m_last     = '0;
        m_last_sat = 1'b0;
        exp_q.delete();
    endtask

    // Advance one clock: apply the inputs held during this edge to the model,
    // then return 1 time unit after the edge so new inputs can be driven.
    task automatic tick();
        exp_t e;
        bit   done;
        @(posedge clk);
        m_acc = 1'b0;
        done  = 1'b0;
        if (rstP) begin
            model_reset();
        end else begin
            m_acc = p_valid && exp_ready();
            if (clr) begin
                m_cnt      = 0;
                m_sum      = 0;
                m_full     = 1'b0;
                m_last_sat = 1'b0;
                exp_q.delete();
            end else begin
                if (m_acc) begin
                    m_sum = m_sum + longint'(p_in);
                    m_cnt++;
                    if (m_cnt == TERMS) begin
                        e = ref_result(m_sum);
                        exp_q.push_back(e);
                        m_last     = e.val;
                        m_last_sat = e.sat;
                        m_cnt      = 0;
                        m_sum      = 0;
                        done       = 1'b1;
                    end
                end
                if (done) m_full = 1'b1;
                else if (m_full && sum_ready) m_full = 1'b0;
            end
        end
        #1;
    endtask

    task automatic send(input logic signed [31:0] p, input logic sr);
        int n;
        p_valid   = 1'b1;
        p_in      = p;
        sum_ready = sr;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 100);
        if (!m_acc) chk("send_timeout", 64'(n), 64'(0));
        p_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic sr);
        p_valid   = 1'b0;
        sum_ready = sr;
        repeat (n) tick();
    endtask

    // Monitor: status outputs every cycle, results on each handshake.
    always @(negedge clk) begin
        if (!rstP) begin
            chk("sum_valid", sum_valid, m_full);
            chk("term_cnt", term_cnt, m_cnt);
            chk("busy", busy, (m_cnt != 0) || m_full);
            chk("p_ready", p_ready, exp_ready());
            chk("sum_out_hold", sum_out, m_last);
`ifdef IDCT_ACC_SAT_EN
            chk("sat_flag_hold", sat_flag, m_last_sat);
`endif
            if (sum_valid && sum_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_result", sum_out, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_result", sum_out, mon_e.val);
`ifdef IDCT_ACC_SAT_EN
                    chk("sb_sat_flag", sat_flag, mon_e.sat);
`endif
                end
            end
        end
    end

    initial begin
        rstP = 1'b1;
        tick();
        tick();
        rstP = 1'b0;
        idle(2, 1'b1);
        chk("reset_sum_out", sum_out, 16'h0000);
        chk("reset_p_ready", p_ready, 1'b1);

        // Eight products of 256 -> 8, visible one cycle after the last accept.
        repeat (8) send(256, 1'b1);
        chk("basic_valid", sum_valid, 1'b1);
        chk("basic_out", sum_out, 16'd8);
        chk("basic_cnt", term_cnt, 4'd0);
        idle(2, 1'b1);

        // Rounding, positive and negative.
        send(384, 1'b1);
        repeat (7) send(0, 1'b1);
        chk("round_pos", sum_out, 16'd2);
        send(-384, 1'b1);
        repeat (7) send(0, 1'b1);
        chk("round_neg", sum_out, 16'hFFFF);
        idle(2, 1'b1);

        // Overflow of the 16-bit result.
        repeat (8) send(32'sh7FFF_FFFF, 1'b1);
`ifdef IDCT_ACC_SAT_EN
        chk("ovf_out", sum_out, 16'h7FFF);
        chk("ovf_sat", sat_flag, 1'b1);
`else
        chk("ovf_out", sum_out, 16'h0000);
`endif
        idle(2, 1'b1);

        // Backpressure: the 16th term waits until the first result pops.
        repeat (15) send(256, 1'b0);
        chk("bp_first_valid", sum_valid, 1'b1);
        p_valid   = 1'b1;
        p_in      = 256;
        sum_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_p_ready_low", p_ready, 1'b0);
            chk("bp_cnt_held", term_cnt, 4'd7);
        end
        sum_ready = 1'b1;
        #1;
        chk("bp_p_ready_high", p_ready, 1'b1);
        tick();
        p_valid = 1'b0;
        chk("bp_second_valid", sum_valid, 1'b1);
        chk("bp_second_out", sum_out, 16'd8);
        idle(2, 1'b1);

        // Pop and completion in the same cycle: no bubble.
        repeat (8) send(256, 1'b0);
        repeat (7) send(1280, 1'b0);
        send(1280, 1'b1);
        chk("popcomp_valid", sum_valid, 1'b1);
        chk("popcomp_out", sum_out, 16'd40);
        idle(2, 1'b1);

        // Flush after 5 terms, with a product offered on the clr cycle.
        repeat (5) send(1000, 1'b1);
        clr     = 1'b1;
        p_valid = 1'b1;
        p_in    = 12345;
        tick();
        clr     = 1'b0;
        p_valid = 1'b0;
        chk("clr_cnt", term_cnt, 4'd0);
        chk("clr_busy", busy, 1'b0);
        repeat (8) send(512, 1'b1);
        chk("clr_out", sum_out, 16'd16);
        idle(2, 1'b1);

        // Asynchronous reset with a pending result and a partial sum.
        repeat (8) send(256, 1'b0);
        repeat (3) send(100, 1'b0);
        #2;
        rstP = 1'b1;
        #1;
        chk("areset_p_ready", p_ready, 1'b1);
        chk("areset_busy", busy, 1'b0);
        chk("areset_valid", sum_valid, 1'b0);
        chk("areset_cnt", term_cnt, 4'd0);
        chk("areset_out", sum_out, 16'd0);
        tick();
        rstP = 1'b0;
        idle(2, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            p_valid   = ($urandom % 4) != 0;
            sum_ready = ($urandom % 3) != 0;
            clr       = ($urandom % 60) == 0;
            case ($urandom % 5)
                0:       p_in = $signed($urandom);
                1:       p_in = 32'sh7FFF_FFFF;
                2:       p_in = 32'sh8000_0000;
                default: p_in = $signed($urandom_range(2000, 0)) - 1000;
            endcase
            tick();
        end
        clr = 1'b0;
        idle(4, 1'b1);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
